// File: rtl/lb_crc4_pkg.sv
// Shared definitions for the CRC-4 localbus transmit framer: FSM encoding,
// CRC polynomial and the default trailer tag.
package lb_crc4_pkg;

  localparam int WORD_W = 16;
  localparam int CRC_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TRAIL = 2'd2
  } state_t;

  // x^4 + x + 1
  localparam logic [CRC_W:0] CRC4_POLY = 5'b1_0011;

  localparam logic [11:0] TRAILER_TAG_DEFAULT = 12'hC40;

endpackage

// File: rtl/lb_crc4_d16_next.sv
// Combinational CRC-4 (x^4+x+1) update over one 16-bit word, data[15] shifted first.
module lb_crc4_d16_next
  import lb_crc4_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [CRC_W-1:0]  crc,
  output logic [CRC_W-1:0]  next
);

  always_comb begin
    next[0] = data[15] ^ data[11] ^ data[10] ^ data[9] ^ data[8] ^ data[6]
            ^ data[4] ^ data[3] ^ data[0] ^ crc[3];
    next[1] = data[15] ^ data[12] ^ data[8] ^ data[7] ^ data[6] ^ data[5]
            ^ data[3] ^ data[1] ^ data[0] ^ crc[0] ^ crc[3];
    next[2] = data[13] ^ data[9] ^ data[8] ^ data[7] ^ data[6] ^ data[4]
            ^ data[2] ^ data[1] ^ crc[1];
    next[3] = data[14] ^ data[10] ^ data[9] ^ data[8] ^ data[7] ^ data[5]
            ^ data[3] ^ data[2] ^ crc[2];
  end

endmodule

// File: rtl/lb_crc4_tx_framer.sv
// Localbus transmit framer: registered payload pass-through with a CRC-4
// trailer word appended after each frame, plus frame counting and over-length cut-off.
module lb_crc4_tx_framer
  import lb_crc4_pkg::*;
#(
  parameter int unsigned      MAX_LEN     = 256,
  parameter logic [CRC_W-1:0] CRC_INIT    = 4'h0,
  parameter logic [11:0]      TRAILER_TAG = TRAILER_TAG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              err_overlen
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t            state_reg;
  logic [CRC_W-1:0]  crc_reg;
  logic [15:0]       cnt_reg;
  logic              forced_reg;
  logic              m_valid_reg;
  logic [WORD_W-1:0] m_data_reg;
  logic              m_last_reg;
  logic [15:0]       frame_cnt_reg;
  logic              err_overlen_reg;

  logic              load_ok;
  logic              s_fire;
  logic [CRC_W-1:0]  crc_seed;
  logic [CRC_W-1:0]  crc_next;
  logic [15:0]       cnt_inc;
  logic              len_hit;

  assign load_ok  = !m_valid_reg || m_ready;
  assign s_ready  = load_ok && (state_reg != TRAIL);
  assign s_fire   = s_valid && s_ready;
  assign crc_seed = (state_reg == IDLE) ? CRC_INIT : crc_reg;
  assign cnt_inc  = cnt_reg + 16'd1;
  assign len_hit  = (cnt_inc == MAX_LEN_W);

  lb_crc4_d16_next u_crc_next (
    .data (s_data),
    .crc  (crc_seed),
    .next (crc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      crc_reg         <= CRC_INIT;
      cnt_reg         <= 16'd0;
      forced_reg      <= 1'b0;
      m_valid_reg     <= 1'b0;
      m_data_reg      <= '0;
      m_last_reg      <= 1'b0;
      frame_cnt_reg   <= 16'd0;
      err_overlen_reg <= 1'b0;
    end else begin
      err_overlen_reg <= 1'b0;
      case (state_reg)
        IDLE, DATA: begin
          if (s_fire) begin
            m_data_reg  <= s_data;
            m_last_reg  <= 1'b0;
            m_valid_reg <= 1'b1;
            crc_reg     <= crc_next;
            if (state_reg == IDLE) begin
              cnt_reg    <= 16'd1;
              forced_reg <= 1'b0;
              state_reg  <= s_last ? TRAIL : DATA;
            end else begin
              cnt_reg    <= cnt_inc;
              // Remember a length cut-off so the error pulse lines up with the trailer load.
              forced_reg <= len_hit && !s_last;
              state_reg  <= (s_last || len_hit) ? TRAIL : DATA;
            end
          end else if (m_ready) begin
            m_valid_reg <= 1'b0;
          end
        end
        TRAIL: begin
          if (load_ok) begin
            m_data_reg      <= {TRAILER_TAG, crc_reg};
            m_last_reg      <= 1'b1;
            m_valid_reg     <= 1'b1;
            frame_cnt_reg   <= frame_cnt_reg + 16'd1;
            err_overlen_reg <= forced_reg;
            forced_reg      <= 1'b0;
            state_reg       <= IDLE;
          end
        end
        default: begin
          state_reg   <= IDLE;
          m_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid     = m_valid_reg;
  assign m_data      = m_data_reg;
  assign m_last      = m_last_reg;
  assign busy        = (state_reg != IDLE);
  assign frame_cnt   = frame_cnt_reg;
  assign err_overlen = err_overlen_reg;

endmodule

// File: doc/lb_crc4_tx_framer.md
Name: lb_crc4_tx_framer

Overview:
- Localbus transmit framer that sits between a localbus word source and the serial/scan link.
- Passes payload words through one registered stage and accumulates a CRC-4 (polynomial x^4+x+1, 16-bit parallel update, first serial bit is D[15]) over every payload word.
- After the last payload word it appends one trailer word carrying the CRC.
- Counts completed frames and force-terminates frames that exceed a maximum length.

Parameters:
- MAX_LEN, 256, maximum payload words per frame (2..65535); reaching it without s_last forces termination.
- CRC_INIT, 4'h0, CRC seed loaded for the first word of each frame.
- TRAILER_TAG, 12'hC40, upper 12 bits of the trailer word.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  payload word valid
- s_ready  out  1  framer accepts the payload word
- s_data  in  16  payload word
- s_last  in  1  last payload word of frame
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts the output word
- m_data  out  16  output word (payload or trailer)
- m_last  out  1  marks the trailer word
- busy  out  1  high while the state is DATA or TRAIL
- frame_cnt  out  16  completed frames (trailers loaded), wraps 0xFFFF->0
- err_overlen  out  1  one-cycle pulse when a frame is force-terminated

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; crc=CRC_INIT.
  - m_valid, m_last, err_overlen = 0; m_data = 0; frame_cnt = 0; word counter = 0.
  - Reset mid-frame discards the frame; no trailer is emitted.
- Handshakes:
  - Transfer happens when valid && ready, on both sides.
  - Output is a single-entry register. load_ok = !m_valid || m_ready.
  - s_ready = load_ok && (state != TRAIL), combinational.
  - m_valid/m_data/m_last hold stable while m_valid && !m_ready.
- FSM states: IDLE, DATA, TRAIL.
  - IDLE, word accepted: crc <= f(s_data, CRC_INIT); cnt <= 1. Next state is TRAIL if s_last, else DATA.
  - DATA, word accepted: crc <= f(s_data, crc); cnt <= cnt+1. Next state is TRAIL if s_last or cnt+1 == MAX_LEN, else stay in DATA.
  - Forced termination (cnt+1 == MAX_LEN && !s_last): err_overlen pulses in the cycle the trailer is loaded. The following input words start a new frame.
  - TRAIL with load_ok: m_data <= {TRAILER_TAG, crc}; m_last <= 1; m_valid <= 1; frame_cnt++; next state IDLE.
  - Payload load: m_data <= s_data, m_last <= 0, m_valid <= 1.
  - Otherwise, on m_ready, m_valid <= 0.
- Latency and throughput:
  - 1 cycle from input accept to m_valid.
  - Trailer is loaded in the cycle after the last payload word is accepted, provided load_ok.
  - Input bubble: exactly 1 cycle per frame (s_ready=0 in TRAIL).
  - Sustained rate: N+1 cycles per N-word frame with m_ready held at 1.
- CRC function f, with d = data and c = crc:
  - n0 = d15^d11^d10^d9^d8^d6^d4^d3^d0^c3
  - n1 = d15^d12^d8^d7^d6^d5^d3^d1^d0^c0^c3
  - n2 = d13^d9^d8^d7^d6^d4^d2^d1^c1
  - n3 = d14^d10^d9^d8^d7^d5^d3^d2^c2
- Single-word frame (s_last in IDLE): valid; the CRC covers that word only.
- s_valid with s_ready=0: no state change; the source must hold its word.

Decomposition:
- Shared package lb_crc4_pkg:
  - state encoding localparams (IDLE=2'd0, DATA=2'd1, TRAIL=2'd2);
  - CRC4 polynomial constant;
  - default TRAILER_TAG.
- One sub-module, lb_crc4_d16_next: combinational next-CRC with inputs data[15:0], crc[3:0] and output next[3:0].
- The FSM, counters and output register live in the top module.

Test Plan:
- Single word: s_data=16'h0001 with s_last, m_ready=1 -> m_data 16'h0001 (m_last=0), then m_data 16'hC403 (m_last=1); frame_cnt=1.
- Two words: 16'h0001, 16'h0000 (last) -> trailer 16'hC406. s_ready is low exactly 1 cycle after the last accept.
- Backpressure: m_ready=0 for 5 cycles mid-frame -> m_data held stable, s_ready=0, CRC unchanged; the same trailer value results after release.
- Overlength with MAX_LEN=4: 6 words with s_last only on word 6.
  - Expected: trailer after word 4 and err_overlen pulses once.
  - Words 5-6 form a second frame with its own trailer; frame_cnt=2.
- Reset mid-frame: rst_n low after 2 of 3 words -> all outputs at 0 immediately. Next frame 16'h8000 (last) -> trailer 16'hC403.
- Back-to-back frames of all-zero words -> trailers 16'hC400; frame_cnt increments per frame. Force frame_cnt to wrap from 0xFFFF to 0.
